cpu_control_unit: RTL and testbench

- Fetch/decode/execute sequencer for the 8-bit microprocessor.
- Fetches 16-bit instructions from instruction memory over a req/ack handshake.
- Decodes each instruction into the 3-bit ALU op, register-file read/write addresses, an immediate and a B-operand select.
- Keeps the PC and zero flag; supports jumps, jump-if-zero and halt.

---
 rtl/cpu_pkg.sv | 51 +++++
 rtl/cpu_instr_decode.sv | 31 +++
 rtl/cpu_control_unit.sv | 118 +++++++++++
 tb/tb_cpu_control_unit.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit CPU control path: ALU op codes, instruction
// field positions, FSM states and the decoded-instruction struct.
package cpu_pkg;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_AND   = 3'b010;
  localparam logic [2:0] ALU_OR    = 3'b011;
  localparam logic [2:0] ALU_XOR   = 3'b100;
  localparam logic [2:0] ALU_NOT   = 3'b101;
  localparam logic [2:0] ALU_PASSB = 3'b110;

  localparam logic [1:0] CLS_RR  = 2'b00;
  localparam logic [1:0] CLS_RI  = 2'b01;
  localparam logic [1:0] CLS_BR  = 2'b10;
  localparam logic [1:0] CLS_SYS = 2'b11;

  localparam logic [2:0] SYS_HALT = 3'b001;

  localparam int CLS_HI = 15, CLS_LO = 14;
  localparam int RSV_B  = 13;
  localparam int OP_HI  = 12, OP_LO  = 10;
  localparam int DST_HI = 9,  DST_LO = 8;
  localparam int SRC_HI = 1,  SRC_LO = 0;
  localparam int IMM_HI = 7,  IMM_LO = 0;

  typedef enum logic [2:0] {
    ST_FETCH,
    ST_DECODE,
    ST_EXECUTE,
`ifdef CU_FETCH_TIMEOUT_EN
    ST_HALT,
    ST_FAULT
`else
    ST_HALT
`endif
  } state_e;

  typedef struct packed {
    logic       is_alu;
    logic       b_imm;
    logic       is_jmp;
    logic       is_jz;
    logic       is_halt;
    logic [2:0] alu_op;
    logic [1:0] dst;
    logic [1:0] src;
    logic [7:0] imm;
  } dec_t;

endpackage

// File: rtl/cpu_instr_decode.sv
// Combinational instruction decoder: 16-bit word -> fields and control flags.
module cpu_instr_decode
  import cpu_pkg::*;
(
  input  logic [15:0] instr,
  output dec_t        dec
);

  logic [1:0] cls;
  logic [2:0] op;
  logic       unused_rsvd;

  assign cls         = instr[CLS_HI:CLS_LO];
  assign op          = instr[OP_HI:OP_LO];
  assign unused_rsvd = instr[RSV_B];

  always_comb begin
    dec         = '0;
    dec.dst     = instr[DST_HI:DST_LO];
    dec.src     = instr[SRC_HI:SRC_LO];
    dec.imm     = instr[IMM_HI:IMM_LO];
    dec.is_alu  = (cls == CLS_RR) || (cls == CLS_RI);
    dec.b_imm   = (cls == CLS_RI);
    // non-ALU classes present a neutral op so the ALU input is deterministic
    dec.alu_op  = dec.is_alu ? op : ALU_ADD;
    dec.is_jmp  = (cls == CLS_BR) && !op[0];
    dec.is_jz   = (cls == CLS_BR) &&  op[0];
    dec.is_halt = (cls == CLS_SYS) && (op == SYS_HALT);
  end

endmodule

// File: rtl/cpu_control_unit.sv
// Fetch/decode/execute sequencer: pc, zero flag and FSM for the 8-bit CPU.
// Optional fetch timeout into a terminal FAULT state with CU_FETCH_TIMEOUT_EN.
module cpu_control_unit
  import cpu_pkg::*;
#(
  parameter int              PC_W        = 8,
  parameter logic [PC_W-1:0] RESET_PC    = '0,
  parameter int              TIMEOUT_CYC = 15
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic [PC_W-1:0] imem_addr,
  output logic            imem_req,
  input  logic            imem_ack,
  input  logic [15:0]     imem_data,
  output logic [1:0]      rf_raddr_a,
  output logic [1:0]      rf_raddr_b,
  output logic [1:0]      rf_waddr,
  output logic            rf_we,
  output logic [2:0]      alu_op,
  output logic            alu_b_imm,
  output logic [7:0]      imm,
  input  logic [7:0]      alu_result,
  output logic            zero,
  output logic            halted,
  output logic            fault
);

  state_e          state, state_nxt;
  logic [PC_W-1:0] pc, pc_nxt;
  logic [15:0]     ir;
  logic            zero_q, req_q, we_q;
  logic            fetch_hit;
  dec_t            dec;

  cpu_instr_decode u_dec (
    .instr (ir),
    .dec   (dec)
  );

  // req is registered so it stays low through reset and rises one cycle after release
  assign fetch_hit = (state == ST_FETCH) && req_q && imem_ack;

`ifdef CU_FETCH_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  logic [CNT_W-1:0] to_cnt;
  logic             to_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                         to_cnt <= '0;
    else if (state == ST_FETCH && req_q) to_cnt <= to_cnt + 1'b1;
    else                                 to_cnt <= '0;
  end

  assign to_hit = (state == ST_FETCH) && req_q && !imem_ack &&
                  (to_cnt == CNT_W'(TIMEOUT_CYC - 1));
  assign fault  = (state == ST_FAULT);
`else
  localparam int unused_timeout = TIMEOUT_CYC;
  assign fault = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    case (state)
      ST_FETCH: begin
        if (fetch_hit) state_nxt = ST_DECODE;
`ifdef CU_FETCH_TIMEOUT_EN
        else if (to_hit) state_nxt = ST_FAULT;
`endif
      end
      ST_DECODE: state_nxt = ST_EXECUTE;
      ST_EXECUTE: begin
        state_nxt = ST_FETCH;
        pc_nxt    = pc + PC_W'(1);
        if (dec.is_jmp || (dec.is_jz && zero_q)) begin
          pc_nxt = PC_W'(dec.imm);
        end else if (dec.is_halt) begin
          state_nxt = ST_HALT;
          pc_nxt    = pc;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_FETCH;
      pc     <= RESET_PC;
      ir     <= '0;
      zero_q <= 1'b0;
      req_q  <= 1'b0;
      we_q   <= 1'b0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      req_q <= (state_nxt == ST_FETCH);
      we_q  <= (state_nxt == ST_EXECUTE) && dec.is_alu;
      if (fetch_hit) ir <= imem_data;
      if (state == ST_EXECUTE && dec.is_alu) zero_q <= (alu_result == 8'h00);
    end
  end

  assign imem_addr  = pc;
  assign imem_req   = req_q;
  assign rf_raddr_a = dec.dst;
  assign rf_raddr_b = dec.src;
  assign rf_waddr   = dec.dst;
  assign rf_we      = we_q;
  assign alu_op     = dec.alu_op;
  assign alu_b_imm  = dec.b_imm;
  assign imm        = dec.imm;
  assign zero       = zero_q;
  assign halted     = (state == ST_HALT);

endmodule

// File: tb/tb_cpu_control_unit.sv
// Scoreboard bench for cpu_control_unit: directed programs, monitor-side checking.
module tb_cpu_control_unit;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  imem_addr;
  logic        imem_req, imem_ack;
  logic [15:0] imem_data;
  logic [1:0]  rf_raddr_a, rf_raddr_b, rf_waddr;
  logic        rf_we, alu_b_imm, zero, halted, fault;
  logic [2:0]  alu_op;
  logic [7:0]  imm, alu_result;

  int checks = 0;
  int errors = 0;
  logic [7:0]  exp_addr_q[$];
  logic [17:0] exp_rf_q[$];
  logic [2:0]  snap_op;
  logic        snap_bimm;
  logic [7:0]  snap_imm;

  always #5 clk = ~clk;

  cpu_control_unit #(.PC_W(8), .RESET_PC(8'h00), .TIMEOUT_CYC(15)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_addr(imem_addr), .imem_req(imem_req), .imem_ack(imem_ack), .imem_data(imem_data),
    .rf_raddr_a(rf_raddr_a), .rf_raddr_b(rf_raddr_b), .rf_waddr(rf_waddr), .rf_we(rf_we),
    .alu_op(alu_op), .alu_b_imm(alu_b_imm), .imm(imm), .alu_result(alu_result),
    .zero(zero), .halted(halted), .fault(fault)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // monitor: new fetch request and rf write strobes are popped against the queues
  logic       prev_req = 1'b0;
  logic [7:0] prev_addr = 8'h00;
  always @(negedge clk) begin
    if (imem_req && !prev_req) begin
      if (exp_addr_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL fetch_unexpected: got addr %0h, expected no fetch", imem_addr);
      end else chk("fetch_addr", 32'(imem_addr), 32'(exp_addr_q.pop_front()));
    end
    if (imem_req && prev_req) chk("fetch_addr_stable", 32'(imem_addr), 32'(prev_addr));
    if (rf_we) begin
      if (exp_rf_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL rf_we_unexpected: got waddr %0h, expected no write", rf_waddr);
      end else chk("rf_write", 32'({rf_waddr, rf_raddr_a, rf_raddr_b, alu_op, alu_b_imm, imm}),
                   32'(exp_rf_q.pop_front()));
    end
    prev_req  <= imem_req;
    prev_addr <= imem_addr;
  end

  // entered and left at a negedge; leaves one cycle after EXECUTE
  task automatic do_instr(input logic [15:0] ins, input int dly, input logic [7:0] res,
                          input bit stray, input bit exp_we, input bit exp_req_after);
    int n = 0;
    while (!imem_req && n < 50) begin @(negedge clk); n++; end
    chk("req_seen", 32'(imem_req), 1);
    repeat (dly) begin
      @(negedge clk);
      chk("req_held", 32'(imem_req), 1);
    end
    imem_data = ins; imem_ack = 1'b1; alu_result = res;
    @(negedge clk);
    imem_ack = 1'b0;
    snap_op = alu_op; snap_bimm = alu_b_imm; snap_imm = imm;
    chk("decode_req_low", 32'(imem_req), 0);
    chk("decode_we_low", 32'(rf_we), 0);
    @(negedge clk);
    chk("exec_req_low", 32'(imem_req), 0);
    chk("exec_we", 32'(rf_we), 32'(exp_we));
    if (stray) begin imem_ack = 1'b1; imem_data = 16'hC400; end
    @(negedge clk);
    imem_ack = 1'b0;
    chk("req_after_exec", 32'(imem_req), 32'(exp_req_after));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish, expected finish before 100000");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    rst_n = 1'b0; imem_ack = 1'b0; imem_data = 16'h0; alu_result = 8'h0;
    repeat (2) @(negedge clk);
    chk("rst_req", 32'(imem_req), 0);
    chk("rst_we", 32'(rf_we), 0);
    chk("rst_halted", 32'(halted), 0);
    chk("rst_fault", 32'(fault), 0);
    chk("rst_zero", 32'(zero), 0);
    chk("rst_addr", 32'(imem_addr), 0);
    chk("rst_imm", 32'(imm), 0);

    exp_addr_q.push_back(8'h00);
    rst_n = 1'b1;
    @(negedge clk);
    chk("req_after_reset", 32'(imem_req), 1);

    // ADD R1, #5
    exp_rf_q.push_back({2'd1, 2'd1, 2'd1, ALU_ADD, 1'b1, 8'h05});
    exp_addr_q.push_back(8'h01);
    do_instr(16'h4105, 0, 8'h05, 0, 1, 1);
    chk("a1_op", 32'(snap_op), 32'(ALU_ADD));
    chk("a1_bimm", 32'(snap_bimm), 1);
    chk("a1_imm", 32'(snap_imm), 32'h05);
    chk("a1_zero", 32'(zero), 0);

    // SUB R2,R3 -> 0, then JZ 0x40 taken
    exp_rf_q.push_back({2'd2, 2'd2, 2'd3, ALU_SUB, 1'b0, 8'h03});
    exp_addr_q.push_back(8'h02);
    do_instr(16'h0603, 0, 8'h00, 0, 1, 1);
    chk("a2_zero", 32'(zero), 1);
    exp_addr_q.push_back(8'h40);
    do_instr(16'h8440, 0, 8'h77, 0, 0, 1);
    chk("a3_zero_kept", 32'(zero), 1);

    // SUB -> 1, then JZ falls through
    exp_rf_q.push_back({2'd2, 2'd2, 2'd3, ALU_SUB, 1'b0, 8'h03});
    exp_addr_q.push_back(8'h41);
    do_instr(16'h0603, 0, 8'h01, 0, 1, 1);
    chk("a4_zero", 32'(zero), 0);
    exp_addr_q.push_back(8'h42);
    do_instr(16'h8440, 0, 8'h00, 0, 0, 1);
    chk("a5_zero", 32'(zero), 0);

    // XOR R3,#A5 with 4 wait cycles and a stray HALT ack during EXECUTE
    exp_rf_q.push_back({2'd3, 2'd3, 2'd1, ALU_XOR, 1'b1, 8'hA5});
    exp_addr_q.push_back(8'h43);
    do_instr(16'h53A5, 4, 8'hA5, 1, 1, 1);
    chk("a6_not_halted", 32'(halted), 0);

    // JMP 0xFF, NOP wraps to 0x00, JMP 0x05, JMP 0x10, HALT
    exp_addr_q.push_back(8'hFF);
    do_instr(16'h80FF, 0, 8'h00, 0, 0, 1);
    exp_addr_q.push_back(8'h00);
    do_instr(16'hC000, 0, 8'h00, 0, 0, 1);
    exp_addr_q.push_back(8'h05);
    do_instr(16'h8005, 0, 8'h00, 0, 0, 1);
    exp_addr_q.push_back(8'h10);
    do_instr(16'h8010, 0, 8'h00, 0, 0, 1);
    do_instr(16'hC400, 0, 8'h00, 0, 0, 0);
    chk("halted", 32'(halted), 1);
    chk("halt_pc", 32'(imem_addr), 32'h10);
    bad = 0;
    repeat (20) begin
      @(negedge clk);
      if (imem_req || rf_we || !halted) bad++;
    end
    chk("halt_quiet", 32'(bad), 0);

    // reset out of HALT, then reset again in the middle of a fetch
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_clears_halt", 32'(halted), 0);
    exp_addr_q.push_back(8'h00);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("midfetch_req", 32'(imem_req), 1);
    imem_data = 16'h4105; imem_ack = 1'b1;
    #2 rst_n = 1'b0;
    #1 chk("reset_drops_req", 32'(imem_req), 0);
    @(negedge clk);
    imem_ack = 1'b0;
    exp_addr_q.push_back(8'h00);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_req", 32'(imem_req), 1);
    chk("ack_discarded_imm", 32'(imm), 0);
`ifdef CU_FETCH_TIMEOUT_EN
    repeat (14) @(negedge clk);
    chk("to_fault_early", 32'(fault), 0);
    chk("to_req_early", 32'(imem_req), 1);
    @(negedge clk);
    chk("to_fault", 32'(fault), 1);
    chk("to_req_drop", 32'(imem_req), 0);
    chk("to_not_halted", 32'(halted), 0);
`else
    repeat (20) @(negedge clk);
    chk("no_to_fault", 32'(fault), 0);
    chk("no_to_req", 32'(imem_req), 1);
`endif
    chk("fetch_q_empty", 32'(exp_addr_q.size()), 0);
    chk("rf_q_empty", 32'(exp_rf_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
